// File: rtl/temperature_anomaly_filter_pkg.sv
// temperature_anomaly_pkg
//   Shared defaults, the acceptance-decision enum and a width helper for the
//   temperature anomaly filter and its serial receiver.
package temperature_anomaly_pkg;

  localparam int DEF_WIDTH          = 16;
  localparam int DEF_DEPTH_LOG2     = 4;
  localparam int DEF_TOL_SHIFT      = 3;
  localparam int DEF_REBASE_COUNT   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 16;

  // Outcome for each received word.
  typedef enum logic [1:0] {
    ACCEPT_WARMUP,
    ACCEPT_IN_BAND,
    ACCEPT_REBASE,
    REJECT
  } decision_e;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/temperature_anomaly_filter_if.sv
// temperature_anomaly_filter_if
//   Bundles the sensor serial bus (sda/scl) and the validated-temperature
//   result signals of the filter.
//   master : sensor/consumer side (drives sda/scl, observes results)
//   slave  : filter side (receives sda/scl, drives results)
interface temperature_anomaly_filter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             sda;
  logic             scl;
  logic             temperatureReady;
  logic [WIDTH-1:0] temperature;
  logic             anomaly;
  logic [WIDTH-1:0] anomalyTemperature;
  logic [CNT_W-1:0] anomalyCount;
  logic [WIDTH-1:0] averageTemperature;
  logic             historyFull;
  logic             rebase;

  modport master (
    output sda, scl,
    input  temperatureReady, temperature, anomaly, anomalyTemperature,
           anomalyCount, averageTemperature, historyFull, rebase
  );

  modport slave (
    input  sda, scl,
    output temperatureReady, temperature, anomaly, anomalyTemperature,
           anomalyCount, averageTemperature, historyFull, rebase
  );
endinterface

// File: rtl/temperature_anomaly_filter_receiver.sv
// serial_sample_receiver
//   Synchronises sda/scl into the clk domain, samples sda on each scl rise
//   (MSB first) and emits a WIDTH-bit word with a one-cycle valid pulse.
//   A partial frame is discarded after TIMEOUT_CYCLES clocks without an scl
//   rise.
//   Ports: clk, rst (async, active-high), i_sda, i_scl (asynchronous),
//          o_word (last complete word), o_word_valid (one-cycle pulse).
import temperature_anomaly_pkg::*;

module serial_sample_receiver #(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sda,
  input  logic             i_scl,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid
);

  localparam int BIT_W = clog2_min1(WIDTH + 1);
  localparam int TO_W  = clog2_min1(TIMEOUT_CYCLES + 1);

  logic [1:0]       r_scl_sync;
  logic [1:0]       r_sda_sync;
  logic             r_scl_prev;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [TO_W-1:0]  r_timeout;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;

  logic             w_scl_rise;
  logic [WIDTH-1:0] w_next_shift;

  assign w_scl_rise   = r_scl_sync[1] & ~r_scl_prev;
  assign w_next_shift = {r_shift[WIDTH-2:0], r_sda_sync[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync   <= '0;
      r_sda_sync   <= '0;
      r_scl_prev   <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_timeout    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_scl_sync   <= {r_scl_sync[0], i_scl};
      r_sda_sync   <= {r_sda_sync[0], i_sda};
      r_scl_prev   <= r_scl_sync[1];
      r_word_valid <= 1'b0;

      if (w_scl_rise) begin
        r_timeout <= '0;
        r_shift   <= w_next_shift;
        if (r_bit_cnt == BIT_W'(WIDTH - 1)) begin
          r_bit_cnt    <= '0;
          r_word       <= w_next_shift;
          r_word_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
      end else if (r_bit_cnt != '0) begin
        // Idle count only runs while a frame is partially received.
        if (r_timeout == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= '0;
          r_timeout <= '0;
        end else begin
          r_timeout <= r_timeout + TO_W'(1);
        end
      end else begin
        r_timeout <= '0;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/temperature_anomaly_filter.sv
// temperature_anomaly_filter
//   Validates serial temperature samples against a tolerance window around
//   the average of a ring-buffer history. Rejections are reported and
//   counted; REBASE_COUNT consecutive rejections flush the history and
//   restart it from the triggering sample.
//   Ports: clk, reset (async, active-high),
//          bus (slave modport): sda/scl in; temperatureReady, temperature,
//          anomaly, anomalyTemperature, anomalyCount, averageTemperature,
//          historyFull, rebase out.
import temperature_anomaly_pkg::*;

module temperature_anomaly_filter #(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
  parameter int TOL_SHIFT      = DEF_TOL_SHIFT,
  parameter int REBASE_COUNT   = DEF_REBASE_COUNT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  temperature_anomaly_filter_if.slave  bus
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SUM_W  = WIDTH + DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam int REJ_W  = clog2_min1(REBASE_COUNT + 1);

  logic [WIDTH-1:0]      w_word;
  logic                  w_word_valid;

  logic [WIDTH-1:0]      r_hist [DEPTH];
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [FILL_W-1:0]     r_fill;
  logic [SUM_W-1:0]      r_sum;
  logic [WIDTH-1:0]      r_avg;
  logic [WIDTH:0]        r_upper;
  logic [WIDTH-1:0]      r_lower;
  logic [REJ_W-1:0]      r_rej_cnt;

  logic                  r_ready;
  logic [WIDTH-1:0]      r_temp;
  logic                  r_anomaly;
  logic [WIDTH-1:0]      r_anom_temp;
  logic [CNT_W-1:0]      r_anom_cnt;
  logic                  r_rebase;

  logic                  w_full;
  logic [WIDTH-1:0]      w_oldest;
  logic [SUM_W-1:0]      w_sum_next;
  decision_e             w_decision;

  serial_sample_receiver #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .rst          (reset),
    .i_sda        (bus.sda),
    .i_scl        (bus.scl),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_full   = (r_fill == FILL_W'(DEPTH));
  assign w_oldest = r_hist[r_ptr];
  // The oldest entry only leaves the sum once the ring is full.
  assign w_sum_next = r_sum + SUM_W'(w_word) - (w_full ? SUM_W'(w_oldest) : '0);

  always_comb begin
    w_decision = REJECT;
    if (!w_full) begin
      w_decision = ACCEPT_WARMUP;
    end else if ((w_word > r_lower) && ({1'b0, w_word} < r_upper)) begin
      w_decision = ACCEPT_IN_BAND;
    end else if (r_rej_cnt == REJ_W'(REBASE_COUNT - 1)) begin
      w_decision = ACCEPT_REBASE;
    end
  end

  // History storage needs no reset: entries are only read once every slot
  // has been written since the last reset or rebase.
  always_ff @(posedge clk) begin
    if (w_word_valid) begin
      case (w_decision)
        ACCEPT_WARMUP, ACCEPT_IN_BAND: r_hist[r_ptr] <= w_word;
        ACCEPT_REBASE:                 r_hist[0]     <= w_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_avg       <= '0;
      r_upper     <= '0;
      r_lower     <= '0;
      r_rej_cnt   <= '0;
      r_ready     <= 1'b0;
      r_temp      <= '0;
      r_anomaly   <= 1'b0;
      r_anom_temp <= '0;
      r_anom_cnt  <= '0;
      r_rebase    <= 1'b0;
    end else begin
      r_ready   <= 1'b0;
      r_anomaly <= 1'b0;
      r_rebase  <= 1'b0;

      // Average then bounds trail the sum by one cycle each.
      r_avg   <= r_sum[SUM_W-1:DEPTH_LOG2];
      r_upper <= {1'b0, r_avg} + (WIDTH+1)'(r_avg >> TOL_SHIFT);
      r_lower <= r_avg - (r_avg >> TOL_SHIFT);

      if (w_word_valid) begin
        case (w_decision)
          ACCEPT_WARMUP, ACCEPT_IN_BAND: begin
            r_ptr     <= r_ptr + DEPTH_LOG2'(1);
            r_sum     <= w_sum_next;
            r_fill    <= w_full ? r_fill : r_fill + FILL_W'(1);
            r_rej_cnt <= '0;
            r_ready   <= 1'b1;
            r_temp    <= w_word;
          end
          ACCEPT_REBASE: begin
            // Flush and restart with the triggering word as sample one.
            r_ptr     <= DEPTH_LOG2'(1);
            r_sum     <= SUM_W'(w_word);
            r_fill    <= FILL_W'(1);
            r_rej_cnt <= '0;
            r_ready   <= 1'b1;
            r_temp    <= w_word;
            r_rebase  <= 1'b1;
          end
          default: begin
            r_anomaly   <= 1'b1;
            r_anom_temp <= w_word;
            r_rej_cnt   <= r_rej_cnt + REJ_W'(1);
            if (r_anom_cnt != '1) begin
              r_anom_cnt <= r_anom_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.temperatureReady   = r_ready;
  assign bus.temperature        = r_temp;
  assign bus.anomaly            = r_anomaly;
  assign bus.anomalyTemperature = r_anom_temp;
  assign bus.anomalyCount       = r_anom_cnt;
  assign bus.averageTemperature = r_avg;
  assign bus.historyFull        = w_full;
  assign bus.rebase             = r_rebase;

endmodule

// File: tb/tb_temperature_anomaly_filter.sv
module tb_temperature_anomaly_filter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sda = 1'b0;
  logic scl = 1'b0;

  int checks = 0;
  int errors = 0;

  int ready_cnt = 0;
  int anom_cnt = 0;
  int rebase_cnt = 0;
  int anom2_cnt = 0;

  always #5 clk = ~clk;

  temperature_anomaly_filter_if #(.WIDTH(16), .CNT_W(16)) bus1 ();
  temperature_anomaly_filter_if #(.WIDTH(16), .CNT_W(4))  bus2 ();

  assign bus1.sda = sda;
  assign bus1.scl = scl;
  assign bus2.sda = sda;
  assign bus2.scl = scl;

  temperature_anomaly_filter #(
    .WIDTH(16), .DEPTH_LOG2(4), .TOL_SHIFT(3), .REBASE_COUNT(4),
    .TIMEOUT_CYCLES(1024), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Small counter width and no practical rebase, for saturation.
  temperature_anomaly_filter #(
    .WIDTH(16), .DEPTH_LOG2(4), .TOL_SHIFT(3), .REBASE_COUNT(64),
    .TIMEOUT_CYCLES(1024), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always @(negedge clk) begin
    if (bus1.temperatureReady === 1'b1) ready_cnt++;
    if (bus1.anomaly === 1'b1)          anom_cnt++;
    if (bus1.rebase === 1'b1)           rebase_cnt++;
    if (bus2.anomaly === 1'b1)          anom2_cnt++;
  end

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sda = w[i];
      repeat (4) @(negedge clk);
      scl = 1'b1;
      repeat (4) @(negedge clk);
      scl = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_bits(w, 16);
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int r0;
    repeat (3) @(negedge clk);
    checks++; if (bus1.temperature !== 16'd0) begin errors++; $display("FAIL reset_temp: got %0d expected 0", bus1.temperature); end
    checks++; if (bus1.anomalyCount !== 16'd0) begin errors++; $display("FAIL reset_acnt: got %0d expected 0", bus1.anomalyCount); end
    checks++; if ({bus1.temperatureReady, bus1.anomaly, bus1.rebase, bus1.historyFull} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus1.temperatureReady, bus1.anomaly, bus1.rebase, bus1.historyFull}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) send_frame(16'd800);
    checks++; if (bus1.temperature !== 16'd800) begin errors++; $display("FAIL pre_reset_temp: got %0d expected 800", bus1.temperature); end
    checks++; if (bus1.averageTemperature !== 16'd150) begin errors++; $display("FAIL pre_reset_avg: got %0d expected 150", bus1.averageTemperature); end
    send_bits(16'hFFFF, 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus1.temperature !== 16'd0) begin errors++; $display("FAIL async_reset_temp: got %0d expected 0", bus1.temperature); end
    checks++; if (bus1.averageTemperature !== 16'd0) begin errors++; $display("FAIL async_reset_avg: got %0d expected 0", bus1.averageTemperature); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    r0 = ready_cnt;
    send_frame(16'd800);
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL post_reset_ready: got %0d expected 1", ready_cnt - r0); end
    checks++; if (bus1.temperature !== 16'd800) begin errors++; $display("FAIL post_reset_temp: got %0d expected 800", bus1.temperature); end
  endtask

  task automatic test_warmup();
    int r0, a0;
    do_reset();
    r0 = ready_cnt; a0 = anom_cnt;
    for (int i = 0; i < 15; i++) send_frame(16'd800);
    checks++; if (bus1.historyFull !== 1'b0) begin errors++; $display("FAIL warm_full15: got %b expected 0", bus1.historyFull); end
    send_frame(16'd800);
    checks++; if (ready_cnt - r0 !== 16) begin errors++; $display("FAIL warm_ready: got %0d expected 16", ready_cnt - r0); end
    checks++; if (anom_cnt - a0 !== 0) begin errors++; $display("FAIL warm_anom: got %0d expected 0", anom_cnt - a0); end
    checks++; if (bus1.historyFull !== 1'b1) begin errors++; $display("FAIL warm_full16: got %b expected 1", bus1.historyFull); end
    checks++; if (bus1.averageTemperature !== 16'd800) begin errors++; $display("FAIL warm_avg: got %0d expected 800", bus1.averageTemperature); end
  endtask

  // Runs on the full 800 history left by test_warmup; bounds 700/900.
  task automatic test_band();
    int r0, a0, b0;
    r0 = ready_cnt; a0 = anom_cnt; b0 = rebase_cnt;
    send_frame(16'd1000);
    checks++; if (anom_cnt - a0 !== 1) begin errors++; $display("FAIL band_1000_pulse: got %0d expected 1", anom_cnt - a0); end
    checks++; if (bus1.anomalyTemperature !== 16'd1000) begin errors++; $display("FAIL band_1000_atemp: got %0d expected 1000", bus1.anomalyTemperature); end
    checks++; if (bus1.anomalyCount !== 16'd1) begin errors++; $display("FAIL band_1000_acnt: got %0d expected 1", bus1.anomalyCount); end
    checks++; if (bus1.temperature !== 16'd800) begin errors++; $display("FAIL band_1000_temp: got %0d expected 800", bus1.temperature); end
    send_frame(16'd900);
    checks++; if (bus1.anomalyTemperature !== 16'd900) begin errors++; $display("FAIL band_upper_strict: got %0d expected 900", bus1.anomalyTemperature); end
    send_frame(16'd700);
    checks++; if (bus1.anomalyTemperature !== 16'd700) begin errors++; $display("FAIL band_lower_strict: got %0d expected 700", bus1.anomalyTemperature); end
    checks++; if (bus1.anomalyCount !== 16'd3) begin errors++; $display("FAIL band_acnt3: got %0d expected 3", bus1.anomalyCount); end
    checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL band_no_ready: got %0d expected 0", ready_cnt - r0); end
    send_frame(16'd850);
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL band_850_ready: got %0d expected 1", ready_cnt - r0); end
    checks++; if (bus1.temperature !== 16'd850) begin errors++; $display("FAIL band_850_temp: got %0d expected 850", bus1.temperature); end
    checks++; if (bus1.averageTemperature !== 16'd803) begin errors++; $display("FAIL band_850_avg: got %0d expected 803", bus1.averageTemperature); end
    // Reject counter was cleared by the accept, so this is a plain reject.
    send_frame(16'd1000);
    checks++; if (rebase_cnt - b0 !== 0) begin errors++; $display("FAIL band_no_rebase: got %0d expected 0", rebase_cnt - b0); end
    checks++; if (bus1.anomalyCount !== 16'd4) begin errors++; $display("FAIL band_acnt4: got %0d expected 4", bus1.anomalyCount); end
  endtask

  task automatic test_rebase();
    int r0, a0, b0;
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(16'd800);
    r0 = ready_cnt; a0 = anom_cnt; b0 = rebase_cnt;
    for (int i = 0; i < 3; i++) send_frame(16'd2000);
    checks++; if (anom_cnt - a0 !== 3) begin errors++; $display("FAIL rb_anom3: got %0d expected 3", anom_cnt - a0); end
    checks++; if (rebase_cnt - b0 !== 0) begin errors++; $display("FAIL rb_early: got %0d expected 0", rebase_cnt - b0); end
    send_frame(16'd2000);
    checks++; if (rebase_cnt - b0 !== 1) begin errors++; $display("FAIL rb_pulse: got %0d expected 1", rebase_cnt - b0); end
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL rb_ready: got %0d expected 1", ready_cnt - r0); end
    checks++; if (bus1.temperature !== 16'd2000) begin errors++; $display("FAIL rb_temp: got %0d expected 2000", bus1.temperature); end
    checks++; if (bus1.historyFull !== 1'b0) begin errors++; $display("FAIL rb_full: got %b expected 0", bus1.historyFull); end
    checks++; if (bus1.anomalyCount !== 16'd3) begin errors++; $display("FAIL rb_acnt: got %0d expected 3", bus1.anomalyCount); end
    r0 = ready_cnt; a0 = anom_cnt;
    for (int i = 0; i < 15; i++) send_frame(16'(100 * i + 50));
    checks++; if (ready_cnt - r0 !== 15) begin errors++; $display("FAIL rb_refill_ready: got %0d expected 15", ready_cnt - r0); end
    checks++; if (anom_cnt - a0 !== 0) begin errors++; $display("FAIL rb_refill_anom: got %0d expected 0", anom_cnt - a0); end
    checks++; if (bus1.historyFull !== 1'b1) begin errors++; $display("FAIL rb_refill_full: got %b expected 1", bus1.historyFull); end
    checks++; if (bus1.averageTemperature !== 16'd828) begin errors++; $display("FAIL rb_refill_avg: got %0d expected 828", bus1.averageTemperature); end
  endtask

  task automatic test_timeout();
    int r0;
    do_reset();
    r0 = ready_cnt;
    send_bits(16'hFFFF, 7);
    repeat (1030) @(negedge clk);
    send_frame(16'd800);
    repeat (20) @(negedge clk);
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL to_words: got %0d expected 1", ready_cnt - r0); end
    checks++; if (bus1.temperature !== 16'd800) begin errors++; $display("FAIL to_value: got %0d expected 800", bus1.temperature); end
  endtask

  task automatic test_saturate();
    int a0;
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(16'd800);
    a0 = anom2_cnt;
    for (int i = 0; i < 14; i++) send_frame(16'd2000);
    checks++; if (bus2.anomalyCount !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d expected 14", bus2.anomalyCount); end
    for (int i = 0; i < 3; i++) send_frame(16'd2000);
    checks++; if (bus2.anomalyCount !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", bus2.anomalyCount); end
    checks++; if (anom2_cnt - a0 !== 17) begin errors++; $display("FAIL sat_pulses: got %0d expected 17", anom2_cnt - a0); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_band();
    test_rebase();
    test_timeout();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
